// File: rtl/eth_ch_pkt_sched.sv
// Two-channel packet scheduler: per-channel sample FIFOs, round-robin grant,
// header + PKT_WORDS payload words streamed to the UDP TX port.
module eth_ch_pkt_sched #(
  parameter int DW        = 32,
  parameter int PKT_WORDS = 256,
  parameter int FIFO_AW   = 9
) (
  input  logic          clk,
  input  logic          srstb,
  input  logic [1:0]    ch_en,
  input  logic [DW-1:0] data_1ch,
  input  logic          wr_data_1ch,
  input  logic [DW-1:0] data_2ch,
  input  logic          wr_data_2ch,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sop,
  output logic          m_eop,
  output logic [1:0]    ovf,
  input  logic          ovf_clr,
  output logic [15:0]   pkt_cnt,
  output logic          busy
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int LW    = FIFO_AW + 1;

  localparam logic [LW-1:0]      LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]      LVL_PKT   = LW'(PKT_WORDS);
  localparam logic [LW-1:0]      WCNT_LAST = LW'(PKT_WORDS - 1);
  localparam logic [LW-1:0]      WCNT_PRE  = LW'(PKT_WORDS - 2);
  localparam logic [LW-1:0]      WCNT_ONE  = LW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];

  logic [1:0][FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [1:0][LW-1:0]      lvl_q, lvl_d;
  logic [1:0][15:0]        seq_q, seq_d;
  logic [1:0]              ovf_q, ovf_d, elig_q;
  logic [1:0]              state_q, state_d;
  logic                    gnt_q, gnt_d, prio_q, prio_d;
  logic [LW-1:0]           wcnt_q, wcnt_d;
  logic [DW-1:0]           data_q, data_d;
  logic                    valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [15:0]             pkt_q, pkt_d;

  logic [1:0]    wr_req, wr_ok, rd, ovf_set, avail;
  logic          hs, sel;
  logic [DW-1:0] pay_word;

  assign hs       = valid_q & m_ready;
  assign wr_req   = {wr_data_2ch, wr_data_1ch} & ch_en;
  assign rd       = (state_q == S_PAY && hs) ? {gnt_q, ~gnt_q} : 2'b00;
  assign sel      = (avail == 2'b11) ? prio_q : avail[1];
  assign pay_word = gnt_q ? mem2[rp_q[1]] : mem1[rp_q[0]];

  // A slot still held in the output register counts in the level, so a write
  // can only reuse it in the cycle its payload handshake frees it.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_ok[c]   = wr_req[c] && (lvl_q[c] != LVL_FULL || rd[c]);
      ovf_set[c] = wr_req[c] && lvl_q[c] == LVL_FULL && !rd[c];
      lvl_d[c]   = lvl_q[c] + LW'(wr_ok[c]) - LW'(rd[c]);
      wp_d[c]    = wr_ok[c] ? wp_q[c] + PTR_ONE : wp_q[c];
      // elig_q delays eligibility one cycle; the live level guards against a
      // stale flag right after this channel's own packet drained it.
      avail[c]   = elig_q[c] && lvl_q[c] >= LVL_PKT;
    end
    ovf_d = (ovf_q & ~{2{ovf_clr}}) | ovf_set;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    wcnt_d  = wcnt_q;
    rp_d    = rp_q;
    seq_d   = seq_q;
    pkt_d   = pkt_q;
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    case (state_q)
      S_IDLE: begin
        if (avail != 2'b00) begin
          state_d = S_HDR;
          gnt_d   = sel;
          data_d  = {8'hA5, (sel ? 8'd2 : 8'd1), seq_q[sel]};
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
        end
      end
      S_HDR: begin
        if (hs) begin
          state_d      = S_PAY;
          data_d       = pay_word;
          sop_d        = 1'b0;
          eop_d        = 1'b0;
          wcnt_d       = '0;
          rp_d[gnt_q]  = rp_q[gnt_q] + PTR_ONE;
        end
      end
      S_PAY: begin
        if (hs) begin
          if (wcnt_q == WCNT_LAST) begin
            state_d      = S_IDLE;
            valid_d      = 1'b0;
            eop_d        = 1'b0;
            seq_d[gnt_q] = seq_q[gnt_q] + 16'd1;
            pkt_d        = pkt_q + 16'd1;
            prio_d       = ~gnt_q;
          end else begin
            data_d       = pay_word;
            eop_d        = (wcnt_q == WCNT_PRE);
            wcnt_d       = wcnt_q + WCNT_ONE;
            rp_d[gnt_q]  = rp_q[gnt_q] + PTR_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!srstb) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      wcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      elig_q  <= '0;
      seq_q   <= '0;
      ovf_q   <= '0;
      pkt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      wcnt_q  <= wcnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      elig_q  <= {lvl_q[1] >= LVL_PKT, lvl_q[0] >= LVL_PKT};
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      pkt_q   <= pkt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  // NOTE: storage arrays are not reset; clearing pointers and levels already
  // makes every stored word unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok[0]) mem1[wp_q[0]] <= data_1ch;
    if (wr_ok[1]) mem2[wp_q[1]] <= data_2ch;
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_sop   = sop_q;
  assign m_eop   = eop_q;
  assign ovf     = ovf_q;
  assign pkt_cnt = pkt_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_ch_pkt_sched.sv
// Directed bench for eth_ch_pkt_sched: latency, round robin, backpressure,
// overflow, disabled channel and reset in the middle of a packet.
module tb_eth_ch_pkt_sched;

  localparam int PKT = 256;

  logic        clk = 1'b0;
  logic        srstb = 1'b0;
  logic [1:0]  ch_en = 2'b00;
  logic [31:0] data_1ch = '0, data_2ch = '0;
  logic        wr_data_1ch = 1'b0, wr_data_2ch = 1'b0;
  logic [31:0] m_data;
  logic        m_valid, m_sop, m_eop, busy;
  logic        m_ready = 1'b0;
  logic [1:0]  ovf;
  logic        ovf_clr = 1'b0;
  logic [15:0] pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  eth_ch_pkt_sched dut (
    .clk(clk), .srstb(srstb), .ch_en(ch_en),
    .data_1ch(data_1ch), .wr_data_1ch(wr_data_1ch),
    .data_2ch(data_2ch), .wr_data_2ch(wr_data_2ch),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .ovf(ovf), .ovf_clr(ovf_clr),
    .pkt_cnt(pkt_cnt), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srstb = 1'b0;
    wr_data_1ch = 1'b0;
    wr_data_2ch = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    srstb = 1'b1;
    q1.delete();
    q2.delete();
  endtask

  task automatic write_words(input int ch, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      if (ch == 1) begin
        data_1ch = base + 32'(i); wr_data_1ch = 1'b1; q1.push_back(data_1ch);
      end else begin
        data_2ch = base + 32'(i); wr_data_2ch = 1'b1; q2.push_back(data_2ch);
      end
      tick();
    end
    wr_data_1ch = 1'b0;
    wr_data_2ch = 1'b0;
  endtask

  task automatic write_both(input int n);
    for (int i = 0; i < n; i++) begin
      data_1ch = 32'h1000 + 32'(i); wr_data_1ch = 1'b1; q1.push_back(data_1ch);
      data_2ch = 32'h2000 + 32'(i); wr_data_2ch = 1'b1; q2.push_back(data_2ch);
      tick();
    end
    wr_data_1ch = 1'b0;
    wr_data_2ch = 1'b0;
  endtask

  // Receives one packet, comparing against the per-channel expected queue.
  task automatic recv_pkt(input int ch, input logic [15:0] seq, input bit rnd,
                          input bit inject, output int gap);
    int hs, cyc, bad, bubbles, unstable, flag_bad;
    logic rdy, stall, hold_sop, hold_eop;
    logic [31:0] exp_w, hold_d;
    gap = 0; hs = 0; cyc = 0; bad = 0; bubbles = 0; unstable = 0; flag_bad = 0;
    stall = 1'b0; hold_d = '0; hold_sop = 1'b0; hold_eop = 1'b0;
    while (!m_valid && gap < 2000) begin
      tick();
      gap++;
    end
    check($sformatf("ch%0d_hdr_valid", ch), {31'd0, m_valid}, 32'd1);
    check($sformatf("ch%0d_hdr_word", ch), m_data, {8'hA5, 8'(ch), seq});
    check($sformatf("ch%0d_hdr_sop", ch), {31'd0, m_sop}, 32'd1);
    while (hs < PKT + 1 && cyc < 4000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready = rdy;
      wr_data_1ch = 1'b0;
      if (stall && (!m_valid || m_data !== hold_d || m_sop !== hold_sop || m_eop !== hold_eop))
        unstable++;
      if (hs > 0 && !m_valid) bubbles++;
      if (m_valid && rdy) begin
        if (hs == 0) begin
          if (!m_sop || m_eop) flag_bad++;
        end else begin
          if (ch == 1) begin
            if (q1.size() == 0) bad++;
            else begin exp_w = q1.pop_front(); if (m_data !== exp_w) bad++; end
          end else begin
            if (q2.size() == 0) bad++;
            else begin exp_w = q2.pop_front(); if (m_data !== exp_w) bad++; end
          end
          if (m_sop || (m_eop != (hs == PKT))) flag_bad++;
          if (inject && hs == 1) begin
            data_1ch = 32'h0000_5555;
            wr_data_1ch = 1'b1;
            q1.push_back(data_1ch);
          end
        end
        hs++;
      end
      stall = m_valid && !rdy;
      hold_d = m_data; hold_sop = m_sop; hold_eop = m_eop;
      tick();
      cyc++;
    end
    wr_data_1ch = 1'b0;
    m_ready = 1'b1;
    check($sformatf("ch%0d_handshakes", ch), 32'(hs), 32'(PKT + 1));
    check($sformatf("ch%0d_payload_errs", ch), 32'(bad), 32'd0);
    check($sformatf("ch%0d_sop_eop_errs", ch), 32'(flag_bad), 32'd0);
    if (rnd) check($sformatf("ch%0d_stall_unstable", ch), 32'(unstable), 32'd0);
    else     check($sformatf("ch%0d_bubbles", ch), 32'(bubbles), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int gap;
    int waited;

    // Reset state
    tick();
    tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_sop_eop", {30'd0, m_sop, m_eop}, 32'd0);
    check("rst_ovf", {30'd0, ovf}, 32'd0);
    check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single packet with grant latency
    do_reset();
    ch_en = 2'b01;
    m_ready = 1'b1;
    write_words(1, PKT, 32'd0);
    check("lat_edge0", {31'd0, m_valid}, 32'd0);
    tick();
    check("lat_edge1", {31'd0, m_valid}, 32'd0);
    tick();
    check("lat_edge2", {31'd0, m_valid}, 32'd1);
    recv_pkt(1, 16'h0000, 1'b0, 1'b0, gap);
    check("single_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("single_idle", {31'd0, busy}, 32'd0);

    // Round robin, both channels full
    do_reset();
    ch_en = 2'b11;
    m_ready = 1'b0;
    write_both(512);
    recv_pkt(1, 16'h0000, 1'b0, 1'b0, gap);
    recv_pkt(2, 16'h0000, 1'b0, 1'b0, gap);
    check("rr_gap2", 32'(gap), 32'd1);
    recv_pkt(1, 16'h0001, 1'b0, 1'b0, gap);
    check("rr_gap3", 32'(gap), 32'd1);
    recv_pkt(2, 16'h0001, 1'b0, 1'b0, gap);
    check("rr_gap4", 32'(gap), 32'd1);
    check("rr_pkt_cnt", {16'd0, pkt_cnt}, 32'd4);

    // Backpressure on a ch2 packet
    ch_en = 2'b10;
    m_ready = 1'b0;
    write_words(2, PKT, 32'h3000);
    recv_pkt(2, 16'h0002, 1'b1, 1'b0, gap);
    check("bp_pkt_cnt", {16'd0, pkt_cnt}, 32'd5);

    // Overflow and its flag
    do_reset();
    ch_en = 2'b01;
    m_ready = 1'b0;
    write_words(1, 512, 32'h4000);
    check("ovf_at_full", {30'd0, ovf}, 32'd0);
    data_1ch = 32'hDEAD; wr_data_1ch = 1'b1;
    tick();
    wr_data_1ch = 1'b0;
    check("ovf_set", {30'd0, ovf}, 32'd1);
    data_1ch = 32'hBEEF; wr_data_1ch = 1'b1; ovf_clr = 1'b1;
    tick();
    wr_data_1ch = 1'b0;
    check("ovf_clr_vs_set", {30'd0, ovf}, 32'd1);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", {30'd0, ovf}, 32'd0);
    recv_pkt(1, 16'h0000, 1'b0, 1'b1, gap);
    check("ovf_full_rw", {30'd0, ovf}, 32'd0);
    recv_pkt(1, 16'h0001, 1'b0, 1'b0, gap);
    write_words(1, PKT - 1, 32'h6000);
    recv_pkt(1, 16'h0002, 1'b0, 1'b0, gap);
    check("ovf_end", {30'd0, ovf}, 32'd0);
    check("ovf_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);

    // Disabled channel ignores writes
    ch_en = 2'b01;
    for (int i = 0; i < 600; i++) begin
      data_2ch = 32'hBAD0_0000 + 32'(i);
      wr_data_2ch = 1'b1;
      tick();
    end
    wr_data_2ch = 1'b0;
    tick();
    tick();
    check("dis_ovf", {30'd0, ovf}, 32'd0);
    check("dis_no_valid", {31'd0, m_valid}, 32'd0);
    check("dis_no_busy", {31'd0, busy}, 32'd0);
    ch_en = 2'b10;
    write_words(2, PKT, 32'h7000);
    recv_pkt(2, 16'h0000, 1'b0, 1'b0, gap);

    // Reset in the middle of a packet
    ch_en = 2'b01;
    m_ready = 1'b1;
    write_words(1, PKT, 32'h8000);
    waited = 0;
    while (!m_valid && waited < 100) begin
      tick();
      waited++;
    end
    check("mid_hdr_seen", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 101; i++) tick();
    check("mid_word100", m_data, 32'h8064);
    srstb = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_data", m_data, 32'd0);
    check("mid_rst_flags", {29'd0, m_sop, m_eop, busy}, 32'd0);
    check("mid_rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    srstb = 1'b1;
    q1.delete();
    q2.delete();
    write_words(1, PKT, 32'h9000);
    recv_pkt(1, 16'h0000, 1'b0, 1'b0, gap);
    check("mid_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_ch_pkt_sched.md
# eth_ch_pkt_sched

Two-channel packet scheduler in front of the 1G Ethernet UDP transmit path. It buffers the 32-bit sample streams `data_1ch`/`data_2ch` in one FIFO per channel, builds fixed-length packets, and shares the single UDP payload port between the two channels by round-robin. Every packet carries a header word with the channel ID and a per-channel sequence number.

## Interface
- `DW`, 32, sample/word width (header layout below requires 32)
- `PKT_WORDS`, 256, payload words per packet (2..2^FIFO_AW)
- `FIFO_AW`, 9, per-channel FIFO address width (depth 512)
- `clk` in 1, single clock for the whole block
- `srstb` in 1, synchronous reset, active-low
- `ch_en` in 2, per-channel write enable: bit0 = ch1, bit1 = ch2
- `data_1ch` in DW, ch1 sample
- `wr_data_1ch` in 1, ch1 write strobe, one word per cycle when high
- `data_2ch` in DW, ch2 sample
- `wr_data_2ch` in 1, ch2 write strobe
- `m_data` out DW, packet word to the UDP TX
- `m_valid` out 1, `m_data` is valid
- `m_ready` in 1, UDP TX accepts the word
- `m_sop` out 1, marks the header word
- `m_eop` out 1, marks the last payload word
- `ovf` out 2, sticky per-channel overflow flags
- `ovf_clr` in 1, clears both `ovf` bits
- `pkt_cnt` out 16, total packets completed; wraps
- `busy` out 1, high while the FSM is not in IDLE

## Operation
- **Writes.**
  - A word is written when the channel's `wr` and `ch_en` bit are both high.
  - A write while `ch_en` is low is ignored and does not set `ovf`.
- **Fill level.**
  - Each channel keeps a level counter, 0..2^FIFO_AW.
  - It changes by +1 on a write, −1 on a read, and is unchanged on a simultaneous write and read.
- **Full FIFO.**
  - A write while level == 2^FIFO_AW with no read in the same cycle is dropped, and that channel's `ovf` bit is set.
  - A write while full with a simultaneous read is accepted.
- **Overflow flags.**
  - `ovf_clr` clears the flags.
  - If a new overflow happens in the same cycle as `ovf_clr`, the flag stays set.
- **FSM states:** IDLE, HDR, PAY.
  - **IDLE:**
    - A channel is eligible when its level ≥ PKT_WORDS.
    - If exactly one channel is eligible, it is granted.
    - If both are eligible, the channel not served last is granted. After reset, ch1 has priority.
    - On a grant the FSM goes to HDR.
  - **HDR:**
    - Presents the header: `m_data` = {8'hA5, 8'd(channel: 1 or 2), 16'(seq[channel])}, with `m_sop` = 1.
    - On handshake (`m_valid` && `m_ready`) the FSM goes to PAY.
  - **PAY:**
    - Presents the FIFO words in order, PKT_WORDS of them.
    - `m_eop` = 1 on the last word.
    - On the handshake of the last word: increment `seq[channel]` (16-bit, wraps FFFF→0000), increment `pkt_cnt`, record last-served = channel, go to IDLE.
- **Payload reservation.** PKT_WORDS words are guaranteed present at grant. FIFO reads happen only on a payload handshake; no underflow is possible.
- **`ch_en` deasserted mid-packet.** The packet in progress completes. Words already buffered stay in the FIFO.

## Timing
- **Reset values.** All outputs are 0 at reset: `m_data`, `m_valid`, `m_sop`, `m_eop`, `ovf`, `pkt_cnt`, `busy`. All FIFO levels, seq counters and the last-served pointer are also cleared.
- **Reset mid-packet.** `m_valid` is low after the reset edge and all buffered data is discarded.
- **Write to level.** The level updates on the edge that samples the write.
- **Grant latency.** `m_valid` (header) is high after the 2nd edge following the edge that sampled the write which made level reach PKT_WORDS. This requires the FSM to be in IDLE.
- **Stream rule.** `m_data`, `m_sop` and `m_eop` are registered and stay stable while `m_valid` && !`m_ready`.
- **Valid in a packet.** `m_valid` stays high from the header through the last word. There are no bubbles in a packet as long as `m_ready` is high. The FIFO read must be show-ahead or prefetched to meet this.
- **Packet cost.** A packet occupies PKT_WORDS+1 handshakes. IDLE costs 1 cycle between packets.
- **Back-to-back packets.** With `m_ready` held at 1 and both channels eligible, `m_valid` drops for exactly 1 cycle between packets.

## Test plan
- **Single packet.** Reset, ch_en=2'b01, write 256 words to ch1 (value = index), `m_ready`=1 → `m_valid` is high 2 edges after the 256th write. Header = 32'hA5010000, then payload 0..255 with `m_eop` on 255. `pkt_cnt`=1, then IDLE.
- **Round robin.** Fill both channels to 512 words each → order ch1, ch2, ch1, ch2. Headers A5010000, A5020000, A5010001, A5020001. `pkt_cnt`=4.
- **Backpressure.** Toggle `m_ready` with a random 50% pattern during a ch2 packet → no word is lost or duplicated, `m_data` is stable while stalled, and 257 handshakes are seen.
- **Overflow.** Hold `m_ready`=0 and write 513 words to ch1 → `ovf`=2'b01, level = 512. Pulse `ovf_clr` → `ovf`=0. Write while full in a cycle where a read also occurs → the word is accepted and `ovf` stays 0.
- **Disabled channel.** Write to ch2 with ch_en[1]=0 → no level change and `ovf` not set.
- **Reset mid-packet.** Deassert `srstb` during PAY word 100 → outputs are 0 the next cycle. After release, write 256 words to ch1 → header seq=0000.
